matrix_stack_ctrl: RTL and testbench
====================================

MATRIX_STACK_CTRL -- requirements
Module: matrix_stack_ctrl

Interface
REQ-001 Parameter ELEM_W, 32, width of one matrix element.
REQ-002 Parameter DEPTH, 32, saved-matrix slots per mode, excluding the live top; DEPTH>=1.
REQ-003 Parameter NUM_MODES, 2, independent stacks (0=modelview, 1=projection, further modes allowed).
REQ-004 Parameter ONE_VAL, 32'h3F80_0000, element value of 1.0 used on the identity diagonal.
REQ-005 Derived: MW=max(1,clog2(NUM_MODES)); DW=clog2(DEPTH+1); RW=4*ELEM_W.
REQ-006 clk  in  1  single clock, all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 matrix_mode  in  MW  selects stack for commands and peek.
REQ-009 push_en, pop_en, ident_en, load_en, write_en, err_clr  in  1 each  single-cycle command strobes.
REQ-010 data_in  in  RW  row stream for load.
REQ-011 write_in_0..write_in_3  in  RW each  rows 0..3 for write.
REQ-012 peek_out_0..peek_out_3  out  RW each  rows 0..3 of top matrix of matrix_mode.
REQ-013 depth_out  out  DW  saved-slot count of matrix_mode.
REQ-014 busy  out  1  load in progress.
REQ-015 overflow, underflow, cmd_drop  out  1 each  sticky error flags.

Function
REQ-016 Each mode SHALL hold a live top matrix in registers plus DEPTH saved slots and a pointer sp[m] in 0..DEPTH.
REQ-017 peek_out_* SHALL be combinational from the top registers of matrix_mode; a top update at edge N SHALL be visible after edge N.
REQ-018 depth_out SHALL equal sp[matrix_mode] combinationally.
REQ-019 At most one command SHALL execute per cycle; priority write_en > pop_en > push_en > ident_en > load_en; each lower-priority asserted strobe SHALL set cmd_drop.
REQ-020 write: all four rows of top[matrix_mode] SHALL be replaced by write_in_0..3 in one cycle.
REQ-021 push with sp<DEPTH: slot[sp] <= top, sp <= sp+1, top unchanged.
REQ-022 push with sp==DEPTH: no state change, overflow <= 1.
REQ-023 pop with sp>0: top <= slot[sp-1], sp <= sp-1.
REQ-024 pop with sp==0: no state change, underflow <= 1.
REQ-025 ident: top <= ONE_VAL on diagonal, zero elsewhere; sp unchanged.
REQ-026 load: FSM IDLE->ROW1->ROW2->ROW3->IDLE; on the load_en cycle row0 <= data_in, then rows 1,2,3 <= data_in on the following three consecutive cycles.
REQ-027 Load target mode SHALL be latched on the load_en cycle; matrix_mode changes during ROW1..ROW3 SHALL not redirect the load.
REQ-028 busy SHALL be 1 in ROW1, ROW2, ROW3 and 0 in IDLE.
REQ-029 While busy, all command strobes except err_clr SHALL be ignored and SHALL set cmd_drop.
REQ-030 Top rows not yet overwritten during a load SHALL retain prior values; peek SHALL show partially loaded matrix.
REQ-031 err_clr SHALL clear overflow, underflow, cmd_drop; an error event in the same cycle SHALL win (flag set).
REQ-032 Stacks of different modes SHALL be fully independent; commands on mode m SHALL not alter any other mode.
REQ-033 matrix_mode >= NUM_MODES SHALL execute no command, set cmd_drop, and drive peek/depth to zero.

Reset
REQ-034 rst_n low SHALL immediately set every top to identity, every sp to 0, FSM to IDLE, busy/overflow/underflow/cmd_drop to 0.
REQ-035 Saved slots need no reset; they are unreadable until pushed.
REQ-036 rst_n asserted mid-load SHALL abort the load; after release the top is identity and busy is 0.

Verification
REQ-037 Reset then mode 0 peek -> rows {ONE,0,0,0},{0,ONE,0,0},{0,0,ONE,0},{0,0,0,ONE}; depth_out=0.
REQ-038 load_en with data_in rows A,B,C,D over 4 cycles, matrix_mode toggled to 1 on cycle 2 -> mode 0 top = A..D, mode 1 identity, busy high exactly 3 cycles.
REQ-039 DEPTH=2: write M1, push, write M2, push, push -> overflow=1, depth_out=2; pop -> top=M2 again after one pop? no: pop -> top=M2, depth 1; pop -> top=M1, depth 0; pop -> underflow=1, top=M1.
REQ-040 write_en and pop_en same cycle -> write executes, sp unchanged, cmd_drop=1.
REQ-041 push_en during ROW2 of load -> ignored, depth unchanged, cmd_drop=1; err_clr next cycle -> all flags 0.
REQ-042 rst_n pulsed low during ROW2 -> busy=0, top identity, depth 0 asynchronously before next clk edge.

Source files
------------

// File: rtl/matrix_stack_ctrl_if.sv
// ---------------------------------------------------------------------------
// matrix_stack_ctrl_if
// Bundles the command, data and status signals of matrix_stack_ctrl.
//   matrix_mode            : stack selector for commands and peek
//   push_en .. err_clr     : single-cycle command strobes
//   data_in                : row stream for a 4-cycle load
//   write_in_0..3          : full matrix for a single-cycle write
//   peek_out_0..3          : rows of the top matrix of matrix_mode
//   depth_out              : saved-slot count of matrix_mode
//   busy                   : load in progress
//   overflow/underflow/cmd_drop : sticky error flags
// master drives commands (controller / bench), slave is the stack itself.
// ---------------------------------------------------------------------------
interface matrix_stack_ctrl_if #(
   parameter int ELEM_W    = 32,
   parameter int DEPTH     = 32,
   parameter int NUM_MODES = 2
);
   localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
   localparam int DW = $clog2(DEPTH + 1);
   localparam int RW = 4 * ELEM_W;

   logic [MW-1:0] matrix_mode;
   logic          push_en;
   logic          pop_en;
   logic          ident_en;
   logic          load_en;
   logic          write_en;
   logic          err_clr;
   logic [RW-1:0] data_in;
   logic [RW-1:0] write_in_0;
   logic [RW-1:0] write_in_1;
   logic [RW-1:0] write_in_2;
   logic [RW-1:0] write_in_3;
   logic [RW-1:0] peek_out_0;
   logic [RW-1:0] peek_out_1;
   logic [RW-1:0] peek_out_2;
   logic [RW-1:0] peek_out_3;
   logic [DW-1:0] depth_out;
   logic          busy;
   logic          overflow;
   logic          underflow;
   logic          cmd_drop;

   modport master (
      output matrix_mode, push_en, pop_en, ident_en, load_en, write_en, err_clr,
      output data_in, write_in_0, write_in_1, write_in_2, write_in_3,
      input  peek_out_0, peek_out_1, peek_out_2, peek_out_3,
      input  depth_out, busy, overflow, underflow, cmd_drop
   );

   modport slave (
      input  matrix_mode, push_en, pop_en, ident_en, load_en, write_en, err_clr,
      input  data_in, write_in_0, write_in_1, write_in_2, write_in_3,
      output peek_out_0, peek_out_1, peek_out_2, peek_out_3,
      output depth_out, busy, overflow, underflow, cmd_drop
   );
endinterface

// File: rtl/matrix_stack_ctrl.sv
// ---------------------------------------------------------------------------
// matrix_stack_ctrl
// Per-mode matrix stacks (OpenGL style): each mode keeps a live 4x4 top
// matrix in registers plus DEPTH saved slots. Commands: write (whole matrix),
// push, pop, identity and a 4-cycle row-streamed load.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (tops -> identity, pointers -> 0)
//   bus   : matrix_stack_ctrl_if slave modport (commands, data, status)
// Row packing: element 0 of a row sits in the most significant ELEM_W bits.
// ---------------------------------------------------------------------------
module matrix_stack_ctrl #(
   parameter int                ELEM_W    = 32,
   parameter int                DEPTH     = 32,
   parameter int                NUM_MODES = 2,
   parameter logic [ELEM_W-1:0] ONE_VAL   = ELEM_W'(32'h3F80_0000)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   matrix_stack_ctrl_if.slave   bus
);
   localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
   localparam int DW = $clog2(DEPTH + 1);
   localparam int RW = 4 * ELEM_W;
   localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [DW-1:0]   SP_FULL = DW'(DEPTH);
   localparam logic [DW-1:0]   SP_ZERO = {DW{1'b0}};
   localparam logic [DW-1:0]   SP_ONE  = DW'(1'b1);
   localparam logic [MW:0]     MODE_LIM = (MW+1)'(NUM_MODES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ROW1 = 2'd1,
      ST_ROW2 = 2'd2,
      ST_ROW3 = 2'd3
   } state_t;

   // Row r of the identity matrix: ONE_VAL in element r, zero elsewhere.
   function automatic logic [RW-1:0] ident_row(input int r);
      logic [RW-1:0] row;
      row = {RW{1'b0}};
      for (int e = 0; e < 4; e++) begin
         row = {row[RW-ELEM_W-1:0], (e == r) ? ONE_VAL : {ELEM_W{1'b0}}};
      end
      return row;
   endfunction

   logic [RW-1:0]   top_q  [NUM_MODES][4];
   logic [RW-1:0]   top_d  [NUM_MODES][4];
   logic [DW-1:0]   sp_q   [NUM_MODES];
   logic [DW-1:0]   sp_d   [NUM_MODES];
   state_t          state_q, state_d;
   logic [MW-1:0]   load_mode_q, load_mode_d;
   logic            busy_q, busy_d;
   logic            ovf_q, ovf_d;
   logic            unf_q, unf_d;
   logic            drop_q, drop_d;

   // Saved slots carry no reset; a slot is only read after a push filled it.
   logic [4*RW-1:0] slot_mem [NUM_MODES][DEPTH];
   logic            slot_we_s;
   logic [MW-1:0]   slot_mode_s;
   logic [SW-1:0]   slot_idx_s;
   logic [4*RW-1:0] slot_wdata_s;
   logic [4*RW-1:0] slot_rdata_s;

   logic            mode_valid_s;
   logic            any_cmd_s;
   logic            multi_cmd_s;
   logic            ovf_evt_s, unf_evt_s, drop_evt_s;
   logic [MW-1:0]   mode_s;
   logic [DW-1:0]   sp_cur_s;

   assign mode_s       = bus.matrix_mode;
   assign mode_valid_s = ({1'b0, mode_s} < MODE_LIM);
   assign any_cmd_s    = bus.write_en | bus.pop_en | bus.push_en | bus.ident_en | bus.load_en;
   // More than one strobe: everything below the winner is dropped.
   assign multi_cmd_s  = (bus.write_en & (bus.pop_en | bus.push_en | bus.ident_en | bus.load_en))
                       | (bus.pop_en   & (bus.push_en | bus.ident_en | bus.load_en))
                       | (bus.push_en  & (bus.ident_en | bus.load_en))
                       | (bus.ident_en & bus.load_en);

   // Next-state computation: command decode, load sequencing and error flags.
   always_comb begin
      top_d        = top_q;
      sp_d         = sp_q;
      state_d      = state_q;
      load_mode_d  = load_mode_q;
      ovf_evt_s    = 1'b0;
      unf_evt_s    = 1'b0;
      drop_evt_s   = 1'b0;
      slot_we_s    = 1'b0;
      slot_mode_s  = mode_s;
      slot_idx_s   = {SW{1'b0}};
      slot_wdata_s = {4*RW{1'b0}};
      slot_rdata_s = {4*RW{1'b0}};
      sp_cur_s     = SP_ZERO;

      case (state_q)
         ST_ROW1, ST_ROW2, ST_ROW3: begin
            // Load uses the latched mode, so matrix_mode may move freely here.
            if (state_q == ST_ROW1) begin
               top_d[load_mode_q][1] = bus.data_in;
               state_d = ST_ROW2;
            end else if (state_q == ST_ROW2) begin
               top_d[load_mode_q][2] = bus.data_in;
               state_d = ST_ROW3;
            end else begin
               top_d[load_mode_q][3] = bus.data_in;
               state_d = ST_IDLE;
            end
            drop_evt_s = any_cmd_s;
         end
         ST_IDLE: begin
            if (!mode_valid_s) begin
               drop_evt_s = any_cmd_s;
            end else begin
               sp_cur_s     = sp_q[mode_s];
               drop_evt_s   = multi_cmd_s;
               slot_rdata_s = slot_mem[mode_s][SW'(sp_cur_s - SP_ONE)];
               if (bus.write_en) begin
                  top_d[mode_s][0] = bus.write_in_0;
                  top_d[mode_s][1] = bus.write_in_1;
                  top_d[mode_s][2] = bus.write_in_2;
                  top_d[mode_s][3] = bus.write_in_3;
               end else if (bus.pop_en) begin
                  if (sp_cur_s == SP_ZERO) begin
                     unf_evt_s = 1'b1;
                  end else begin
                     top_d[mode_s][0] = slot_rdata_s[4*RW-1 -: RW];
                     top_d[mode_s][1] = slot_rdata_s[3*RW-1 -: RW];
                     top_d[mode_s][2] = slot_rdata_s[2*RW-1 -: RW];
                     top_d[mode_s][3] = slot_rdata_s[RW-1   -: RW];
                     sp_d[mode_s]     = sp_cur_s - SP_ONE;
                  end
               end else if (bus.push_en) begin
                  if (sp_cur_s == SP_FULL) begin
                     ovf_evt_s = 1'b1;
                  end else begin
                     slot_we_s    = 1'b1;
                     slot_idx_s   = SW'(sp_cur_s);
                     slot_wdata_s = {top_q[mode_s][0], top_q[mode_s][1],
                                     top_q[mode_s][2], top_q[mode_s][3]};
                     sp_d[mode_s] = sp_cur_s + SP_ONE;
                  end
               end else if (bus.ident_en) begin
                  for (int r = 0; r < 4; r++) begin
                     top_d[mode_s][r] = ident_row(r);
                  end
               end else if (bus.load_en) begin
                  top_d[mode_s][0] = bus.data_in;
                  load_mode_d      = mode_s;
                  state_d          = ST_ROW1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A clear and a new error in the same cycle leave the flag set.
      if (bus.err_clr) begin
         ovf_d  = ovf_evt_s;
         unf_d  = unf_evt_s;
         drop_d = drop_evt_s;
      end else begin
         ovf_d  = ovf_q  | ovf_evt_s;
         unf_d  = unf_q  | unf_evt_s;
         drop_d = drop_q | drop_evt_s;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // Control/top-matrix registers with asynchronous reset to identity.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int m = 0; m < NUM_MODES; m++) begin
            for (int r = 0; r < 4; r++) begin
               top_q[m][r] <= ident_row(r);
            end
            sp_q[m] <= SP_ZERO;
         end
         state_q     <= ST_IDLE;
         load_mode_q <= {MW{1'b0}};
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         top_q       <= top_d;
         sp_q        <= sp_d;
         state_q     <= state_d;
         load_mode_q <= load_mode_d;
         busy_q      <= busy_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         drop_q      <= drop_d;
      end
   end

   // Saved-slot storage, written only by a successful push.
   always_ff @(posedge clk) begin
      if (slot_we_s) begin
         slot_mem[slot_mode_s][slot_idx_s] <= slot_wdata_s;
      end
   end

   // Peek/depth view of the selected mode; an unknown mode reads as zero.
   always_comb begin
      if (mode_valid_s) begin
         bus.peek_out_0 = top_q[mode_s][0];
         bus.peek_out_1 = top_q[mode_s][1];
         bus.peek_out_2 = top_q[mode_s][2];
         bus.peek_out_3 = top_q[mode_s][3];
         bus.depth_out  = sp_q[mode_s];
      end else begin
         bus.peek_out_0 = {RW{1'b0}};
         bus.peek_out_1 = {RW{1'b0}};
         bus.peek_out_2 = {RW{1'b0}};
         bus.peek_out_3 = {RW{1'b0}};
         bus.depth_out  = SP_ZERO;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;
   assign bus.cmd_drop  = drop_q;

endmodule

// File: tb/tb_matrix_stack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_matrix_stack_ctrl
// Directed bench for matrix_stack_ctrl (DEPTH=2, two modes). Stimulus is
// applied on the falling edge; each step queues the state expected after the
// next rising edge, and a monitor compares it 1 time unit after that edge.
// Asynchronous-reset checks are queued for "now" and triggered directly.
// ---------------------------------------------------------------------------
module tb_matrix_stack_ctrl;
   localparam int ELEM_W = 32;
   localparam int DEPTH  = 2;
   localparam int NMODE  = 2;
   localparam logic [31:0] ONE = 32'h3F80_0000;
   localparam logic [31:0] Z   = 32'h0000_0000;

   localparam logic [127:0] I0 = {ONE, Z, Z, Z};
   localparam logic [127:0] I1 = {Z, ONE, Z, Z};
   localparam logic [127:0] I2 = {Z, Z, ONE, Z};
   localparam logic [127:0] I3 = {Z, Z, Z, ONE};

   localparam logic [127:0] RA = 128'hAAAA_0000_1111_2222_3333_4444_5555_A0A0;
   localparam logic [127:0] RB = 128'hBBBB_0001_1212_2323_3434_4545_5656_B1B1;
   localparam logic [127:0] RC = 128'hCCCC_0002_1313_2424_3535_4646_5757_C2C2;
   localparam logic [127:0] RD = 128'hDDDD_0003_1414_2525_3636_4747_5858_D3D3;
   localparam logic [127:0] RE = 128'hEEEE_0004_0000_0000_0000_0000_0000_0E0E;
   localparam logic [127:0] RF = 128'hFFFF_0005_0000_0000_0000_0000_0000_0F0F;
   localparam logic [127:0] RG = 128'h1234_0006_0000_0000_0000_0000_0000_0606;
   localparam logic [127:0] RH = 128'h5678_0007_0000_0000_0000_0000_0000_0707;

   // commands: {write, pop, push, ident, load, err_clr}
   localparam logic [5:0] C_NONE = 6'b000000;
   localparam logic [5:0] C_WR   = 6'b100000;
   localparam logic [5:0] C_POP  = 6'b010000;
   localparam logic [5:0] C_PUSH = 6'b001000;
   localparam logic [5:0] C_ID   = 6'b000100;
   localparam logic [5:0] C_LD   = 6'b000010;
   localparam logic [5:0] C_CLR  = 6'b000001;

   typedef struct {
      int           cyc;
      string        name;
      logic [511:0] rows;
      logic [1:0]   depth;
      logic         busy;
      logic [2:0]   flags;   // {overflow, underflow, cmd_drop}
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_fail;
   exp_t exp_q[$];
   event mon_tick;

   matrix_stack_ctrl_if #(.ELEM_W(ELEM_W), .DEPTH(DEPTH), .NUM_MODES(NMODE)) bus ();

   matrix_stack_ctrl #(
      .ELEM_W(ELEM_W), .DEPTH(DEPTH), .NUM_MODES(NMODE), .ONE_VAL(ONE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter and the clocked monitor trigger.
   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         #1 -> mon_tick;
      end
   end

   task automatic chk(input string nm, input string what, input logic [511:0] got, input logic [511:0] want);
      n_checks = n_checks + 1;
      if (got !== want) begin
         n_fail = n_fail + 1;
         $display("FAIL %s %s: got %h expected %h", nm, what, got, want);
      end
   endtask

   // Monitor: compares every queued expectation whose time has come.
   initial begin
      exp_t e;
      forever begin
         @(mon_tick);
         while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            chk(e.name, "rows", {bus.peek_out_0, bus.peek_out_1, bus.peek_out_2, bus.peek_out_3}, e.rows);
            chk(e.name, "depth", 512'(bus.depth_out), 512'(e.depth));
            chk(e.name, "busy", 512'(bus.busy), 512'(e.busy));
            chk(e.name, "flags", 512'({bus.overflow, bus.underflow, bus.cmd_drop}), 512'(e.flags));
         end
      end
   end

   task automatic expect_at(input int when, input string nm,
                            input logic [127:0] r0, input logic [127:0] r1,
                            input logic [127:0] r2, input logic [127:0] r3,
                            input logic [1:0] d, input logic b, input logic [2:0] f);
      exp_t e;
      e.cyc   = when;
      e.name  = nm;
      e.rows  = {r0, r1, r2, r3};
      e.depth = d;
      e.busy  = b;
      e.flags = f;
      exp_q.push_back(e);
   endtask

   // Expectation for the state after the coming rising edge.
   task automatic expn(input string nm,
                       input logic [127:0] r0, input logic [127:0] r1,
                       input logic [127:0] r2, input logic [127:0] r3,
                       input logic [1:0] d, input logic b, input logic [2:0] f);
      expect_at(cyc + 1, nm, r0, r1, r2, r3, d, b, f);
   endtask

   task automatic cmd(input logic [5:0] s, input logic m, input logic [127:0] din);
      @(negedge clk);
      bus.write_en    = s[5];
      bus.pop_en      = s[4];
      bus.push_en     = s[3];
      bus.ident_en    = s[2];
      bus.load_en     = s[1];
      bus.err_clr     = s[0];
      bus.matrix_mode = m;
      bus.data_in     = din;
   endtask

   task automatic set_wr(input logic [127:0] r0, input logic [127:0] r1,
                         input logic [127:0] r2, input logic [127:0] r3);
      bus.write_in_0 = r0;
      bus.write_in_1 = r1;
      bus.write_in_2 = r2;
      bus.write_in_3 = r3;
   endtask

   // Watchdog: the run is short; anything this long means a hang.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus.matrix_mode = 1'b0;
      bus.push_en = 1'b0; bus.pop_en = 1'b0; bus.ident_en = 1'b0;
      bus.load_en = 1'b0; bus.write_en = 1'b0; bus.err_clr = 1'b0;
      bus.data_in = '0;
      set_wr('0, '0, '0, '0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset state, both modes.
      cmd(C_NONE, 1'b0, '0); expn("reset_m0", I0, I1, I2, I3, 2'd0, 1'b0, 3'b000);
      cmd(C_NONE, 1'b1, '0); expn("reset_m1", I0, I1, I2, I3, 2'd0, 1'b0, 3'b000);

      // Load into mode 0 while matrix_mode moves to 1 mid-load.
      cmd(C_LD,   1'b0, RA); expn("load_row0", RA, I1, I2, I3, 2'd0, 1'b1, 3'b000);
      cmd(C_NONE, 1'b0, RB); expn("load_row1", RA, RB, I2, I3, 2'd0, 1'b1, 3'b000);
      cmd(C_NONE, 1'b1, RC); expn("load_row2_m1view", I0, I1, I2, I3, 2'd0, 1'b1, 3'b000);
      cmd(C_NONE, 1'b1, RD); expn("load_done_m1view", I0, I1, I2, I3, 2'd0, 1'b0, 3'b000);
      cmd(C_NONE, 1'b0, '0); expn("load_result_m0", RA, RB, RC, RD, 2'd0, 1'b0, 3'b000);

      // Push/pop with overflow and underflow at DEPTH=2.
      set_wr(RA, RB, RC, RD);
      cmd(C_WR,   1'b0, '0); expn("write_m1", RA, RB, RC, RD, 2'd0, 1'b0, 3'b000);
      cmd(C_PUSH, 1'b0, '0); expn("push1", RA, RB, RC, RD, 2'd1, 1'b0, 3'b000);
      set_wr(RE, RF, RG, RH);
      cmd(C_WR,   1'b0, '0); expn("write_m2", RE, RF, RG, RH, 2'd1, 1'b0, 3'b000);
      cmd(C_PUSH, 1'b0, '0); expn("push2", RE, RF, RG, RH, 2'd2, 1'b0, 3'b000);
      cmd(C_PUSH, 1'b0, '0); expn("push_overflow", RE, RF, RG, RH, 2'd2, 1'b0, 3'b100);
      cmd(C_POP,  1'b0, '0); expn("pop1", RE, RF, RG, RH, 2'd1, 1'b0, 3'b100);
      cmd(C_POP,  1'b0, '0); expn("pop2", RA, RB, RC, RD, 2'd0, 1'b0, 3'b100);
      cmd(C_POP,  1'b0, '0); expn("pop_underflow", RA, RB, RC, RD, 2'd0, 1'b0, 3'b110);
      cmd(C_CLR,  1'b0, '0); expn("err_clr1", RA, RB, RC, RD, 2'd0, 1'b0, 3'b000);

      // Write beats pop in the same cycle; pop is dropped.
      set_wr(RD, RC, RB, RA);
      cmd(C_WR | C_POP, 1'b0, '0); expn("write_vs_pop", RD, RC, RB, RA, 2'd0, 1'b0, 3'b001);
      cmd(C_CLR,  1'b0, '0); expn("err_clr2", RD, RC, RB, RA, 2'd0, 1'b0, 3'b000);

      // Mode independence and identity.
      cmd(C_PUSH, 1'b1, '0); expn("push_m1", I0, I1, I2, I3, 2'd1, 1'b0, 3'b000);
      cmd(C_ID,   1'b0, '0); expn("ident_m0", I0, I1, I2, I3, 2'd0, 1'b0, 3'b000);
      cmd(C_NONE, 1'b1, '0); expn("m1_untouched", I0, I1, I2, I3, 2'd1, 1'b0, 3'b000);

      // Error event wins over err_clr in the same cycle.
      cmd(C_POP | C_CLR, 1'b0, '0); expn("clr_vs_underflow", I0, I1, I2, I3, 2'd0, 1'b0, 3'b010);
      cmd(C_CLR,  1'b0, '0); expn("err_clr3", I0, I1, I2, I3, 2'd0, 1'b0, 3'b000);

      // Push during ROW2 of a load is ignored; err_clr on the last row.
      cmd(C_LD,   1'b0, RE); expn("load2_row0", RE, I1, I2, I3, 2'd0, 1'b1, 3'b000);
      cmd(C_NONE, 1'b0, RF); expn("load2_row1", RE, RF, I2, I3, 2'd0, 1'b1, 3'b000);
      cmd(C_PUSH, 1'b0, RG); expn("push_while_busy", RE, RF, RG, I3, 2'd0, 1'b1, 3'b001);
      cmd(C_CLR,  1'b0, RH); expn("load2_done_clr", RE, RF, RG, RH, 2'd0, 1'b0, 3'b000);

      // Asynchronous reset in the middle of a load.
      cmd(C_LD,   1'b0, RA); expn("load3_row0", RA, RF, RG, RH, 2'd0, 1'b1, 3'b000);
      cmd(C_NONE, 1'b0, RB); expn("load3_row1", RA, RB, RG, RH, 2'd0, 1'b1, 3'b000);
      cmd(C_NONE, 1'b0, RC);
      #1 rst_n = 1'b0;
      #1 expect_at(cyc, "async_rst_m0", I0, I1, I2, I3, 2'd0, 1'b0, 3'b000);
      -> mon_tick;
      #1 bus.matrix_mode = 1'b1;
      #1 expect_at(cyc, "async_rst_m1", I0, I1, I2, I3, 2'd0, 1'b0, 3'b000);
      -> mon_tick;
      @(negedge clk);
      rst_n = 1'b1;
      cmd(C_NONE, 1'b0, RD); expn("after_rst_m0", I0, I1, I2, I3, 2'd0, 1'b0, 3'b000);

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_checks = n_checks + 1;
         n_fail   = n_fail + 1;
         $display("FAIL pending_checks: got %0d unchecked entries expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
